// File: rtl/rrf_alloc_unit_pkg.sv
// Shared types and sizing for the rename-register tag allocator.
// The pointer types wrap modulo RRF_NUM; the count types also hold RRF_NUM itself.
package rrf_alloc_unit_pkg;

    localparam int RRF_NUM  = 64;
    localparam int RRF_SEL  = 6;
    localparam int DP_WIDTH = 2;

    typedef logic [RRF_SEL-1:0] rrf_tag_t;
    typedef logic [RRF_SEL:0]   rrf_cnt_t;
    typedef logic [1:0]         dp_num_t;

    // Zero-extend a 0..2 request/commit count to counter width
    function automatic rrf_cnt_t widen_num(input dp_num_t n);
        return {{(RRF_SEL-1){1'b0}}, n};
    endfunction

    // Zero-extend a pointer distance to counter width
    function automatic rrf_cnt_t widen_tag(input rrf_tag_t t);
        return {1'b0, t};
    endfunction

endpackage

// File: rtl/rrf_alloc_unit_if.sv
// Dispatch/commit/flush signal bundle between DP, COM and the RRF tag allocator.
interface rrf_alloc_unit_if;
    import rrf_alloc_unit_pkg::*;

    dp_num_t  req_num_i;
    logic     stall_dp_i;
    logic     allocatable_o;
    rrf_tag_t dst_rrftag1_o;
    rrf_tag_t dst_rrftag2_o;
    logic     allocate_en1_o;
    logic     allocate_en2_o;
    dp_num_t  com_num_i;
    rrf_tag_t comptr_o;
    rrf_tag_t rrfptr_o;
    rrf_cnt_t freenum_o;
    logic     flush_i;
    rrf_tag_t flush_rrfptr_i;

    modport master (
        output req_num_i, stall_dp_i, com_num_i, flush_i, flush_rrfptr_i,
        input  allocatable_o, dst_rrftag1_o, dst_rrftag2_o, allocate_en1_o,
               allocate_en2_o, comptr_o, rrfptr_o, freenum_o
    );

    modport slave (
        input  req_num_i, stall_dp_i, com_num_i, flush_i, flush_rrfptr_i,
        output allocatable_o, dst_rrftag1_o, dst_rrftag2_o, allocate_en1_o,
               allocate_en2_o, comptr_o, rrfptr_o, freenum_o
    );

endinterface

// File: rtl/rrf_alloc_unit_chk.sv
// Simulation-only guards on the allocator's illegal input combinations.
module rrf_alloc_unit_chk
    import rrf_alloc_unit_pkg::*;
(
    input logic     clk_i,
    input logic     reset_i,
    input dp_num_t  req_num_i,
    input dp_num_t  com_num_i,
    input logic     flush_i,
    input rrf_tag_t squashed_s,
    input rrf_cnt_t freenum_r
);

    rrf_cnt_t in_flight_s;
    assign in_flight_s = rrf_cnt_t'(RRF_NUM) - freenum_r;

    a_req_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        req_num_i != 2'd3);

    a_com_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        widen_num(com_num_i) <= in_flight_s);

    a_squash_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        !flush_i || (widen_tag(squashed_s) <= in_flight_s));

endmodule

// File: rtl/rrf_alloc_unit_ptr_adv.sv
// Circular rename-pointer advance by 0..2 entries; wraps naturally at RRF_NUM.
module rrf_alloc_unit_ptr_adv
    import rrf_alloc_unit_pkg::*;
(
    input  rrf_tag_t ptr,
    input  dp_num_t  inc,
    output rrf_tag_t nxt
);

    assign nxt = ptr + rrf_tag_t'(inc);

endmodule

// File: rtl/rrf_alloc_unit.sv
// RRF tag allocator: grants up to two circular tags per cycle, reclaims on commit,
// and rewinds the allocation pointer on mispredict flush.
module rrf_alloc_unit
    import rrf_alloc_unit_pkg::*;
(
    input logic           clk_i,
    input logic           reset_i,
    rrf_alloc_unit_if.slave bus
);

    rrf_tag_t rrfptr_r;
    rrf_tag_t comptr_r;
    rrf_cnt_t freenum_r;

    logic     allocatable_s;
    logic     en1_s;
    logic     en2_s;
    dp_num_t  grant_cnt_s;
    rrf_tag_t squashed_s;
    rrf_tag_t rrfptr_adv_s;
    rrf_tag_t comptr_adv_s;
    rrf_tag_t rrfptr_nxt_s;
    rrf_cnt_t freenum_nxt_s;

    rrf_alloc_unit_ptr_adv u_rrf_adv (.ptr(rrfptr_r), .inc(grant_cnt_s),   .nxt(rrfptr_adv_s));
    rrf_alloc_unit_ptr_adv u_com_adv (.ptr(comptr_r), .inc(bus.com_num_i), .nxt(comptr_adv_s));

    // Same-cycle grant; registered freenum keeps just-committed tags out until next cycle
    always_comb begin
        allocatable_s = 1'b0;
        grant_cnt_s   = 2'd0;
        if ((bus.req_num_i != 2'd0) && !bus.stall_dp_i && !bus.flush_i &&
            (freenum_r >= widen_num(bus.req_num_i))) begin
            allocatable_s = 1'b1;
        end else begin
            allocatable_s = 1'b0;
        end
        en1_s = allocatable_s && (bus.req_num_i >= 2'd1);
        en2_s = allocatable_s && (bus.req_num_i == 2'd2);
        if (en2_s) begin
            grant_cnt_s = 2'd2;
        end else if (en1_s) begin
            grant_cnt_s = 2'd1;
        end else begin
            grant_cnt_s = 2'd0;
        end
    end

    assign squashed_s = rrfptr_r - bus.flush_rrfptr_i;

    // Flush returns the squashed younger tags; commits in that cycle still count
    always_comb begin
        rrfptr_nxt_s  = rrfptr_adv_s;
        freenum_nxt_s = freenum_r;
        if (bus.flush_i) begin
            rrfptr_nxt_s  = bus.flush_rrfptr_i;
            freenum_nxt_s = freenum_r + widen_num(bus.com_num_i) + widen_tag(squashed_s);
        end else begin
            rrfptr_nxt_s  = rrfptr_adv_s;
            freenum_nxt_s = freenum_r + widen_num(bus.com_num_i) - widen_num(grant_cnt_s);
        end
    end

    // Allocation/commit pointers and free count
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rrfptr_r  <= {RRF_SEL{1'b0}};
            comptr_r  <= {RRF_SEL{1'b0}};
            freenum_r <= rrf_cnt_t'(RRF_NUM);
        end else begin
            rrfptr_r  <= rrfptr_nxt_s;
            comptr_r  <= comptr_adv_s;
            freenum_r <= freenum_nxt_s;
        end
    end

    assign bus.allocatable_o  = allocatable_s;
    assign bus.allocate_en1_o = en1_s;
    assign bus.allocate_en2_o = en2_s;
    assign bus.dst_rrftag1_o  = rrfptr_r;
    assign bus.dst_rrftag2_o  = rrfptr_r + 6'd1;
    assign bus.rrfptr_o       = rrfptr_r;
    assign bus.comptr_o       = comptr_r;
    assign bus.freenum_o      = freenum_r;

    rrf_alloc_unit_chk u_chk (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_num_i (bus.req_num_i),
        .com_num_i (bus.com_num_i),
        .flush_i   (bus.flush_i),
        .squashed_s(squashed_s),
        .freenum_r (freenum_r)
    );

endmodule

// File: tb/tb_rrf_alloc_unit.sv
// Directed bench for the RRF tag allocator: reset, fill, wrap, commit overlap, flush, async reset.
module tb_rrf_alloc_unit;
    import rrf_alloc_unit_pkg::*;

    logic clk;
    logic reset_n;
    int   vec_cnt;
    int   err_cnt;

    rrf_alloc_unit_if bus ();

    rrf_alloc_unit dut (.clk_i(clk), .reset_i(reset_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus just after a falling edge
    task automatic apply(input dp_num_t req, input dp_num_t com, input logic stall,
                         input logic flush, input rrf_tag_t fptr);
        @(negedge clk);
        bus.req_num_i      = req;
        bus.com_num_i      = com;
        bus.stall_dp_i     = stall;
        bus.flush_i        = flush;
        bus.flush_rrfptr_i = fptr;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.rrfptr_o !== 6'd0 || bus.comptr_o !== 6'd0 || bus.freenum_o !== 7'd64) begin
            err_cnt++;
            $display("FAIL reset_state: rrfptr=%0d comptr=%0d freenum=%0d want 0/0/64",
                     bus.rrfptr_o, bus.comptr_o, bus.freenum_o);
        end
        vec_cnt++;
        if (bus.allocatable_o !== 1'b0 || bus.allocate_en1_o !== 1'b0 || bus.allocate_en2_o !== 1'b0 ||
            bus.dst_rrftag1_o !== 6'd0 || bus.dst_rrftag2_o !== 6'd1) begin
            err_cnt++;
            $display("FAIL reset_outputs: alloc=%b en=%b%b tags=%0d,%0d want 0 00 0,1",
                     bus.allocatable_o, bus.allocate_en1_o, bus.allocate_en2_o,
                     bus.dst_rrftag1_o, bus.dst_rrftag2_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
            vec_cnt++;
            if (bus.dst_rrftag1_o !== 6'(2*i) || bus.dst_rrftag2_o !== 6'(2*i+1) ||
                bus.allocate_en1_o !== 1'b1 || bus.allocate_en2_o !== 1'b1 ||
                bus.freenum_o !== 7'(64-2*i)) begin
                err_cnt++;
                $display("FAIL basic_grant[%0d]: tags=%0d,%0d en=%b%b freenum=%0d want %0d,%0d 11 %0d",
                         i, bus.dst_rrftag1_o, bus.dst_rrftag2_o, bus.allocate_en1_o,
                         bus.allocate_en2_o, bus.freenum_o, 2*i, 2*i+1, 64-2*i);
            end
        end
        apply(2'd2, 2'd0, 1'b1, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd58 || bus.allocatable_o !== 1'b0 || bus.allocate_en1_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_block: freenum=%0d alloc=%b en1=%b want 58 0 0",
                     bus.freenum_o, bus.allocatable_o, bus.allocate_en1_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd58 || bus.rrfptr_o !== 6'd6) begin
            err_cnt++;
            $display("FAIL stall_hold: freenum=%0d rrfptr=%0d want 58 6", bus.freenum_o, bus.rrfptr_o);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 32; i++) apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        apply(2'd2, 2'd1, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd0 || bus.allocatable_o !== 1'b0 || bus.allocate_en1_o !== 1'b0 ||
            bus.allocate_en2_o !== 1'b0 || bus.rrfptr_o !== 6'd0 || bus.comptr_o !== 6'd0) begin
            err_cnt++;
            $display("FAIL fill_full: freenum=%0d alloc=%b en=%b%b rrfptr=%0d comptr=%0d want 0 0 00 0 0",
                     bus.freenum_o, bus.allocatable_o, bus.allocate_en1_o, bus.allocate_en2_o,
                     bus.rrfptr_o, bus.comptr_o);
        end
        apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd1 || bus.allocatable_o !== 1'b0 || bus.allocate_en1_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL fill_no_partial: freenum=%0d alloc=%b en1=%b want 1 0 0",
                     bus.freenum_o, bus.allocatable_o, bus.allocate_en1_o);
        end
        bus.req_num_i = 2'd1;
        #1;
        vec_cnt++;
        if (bus.allocatable_o !== 1'b1 || bus.allocate_en1_o !== 1'b1 || bus.allocate_en2_o !== 1'b0 ||
            bus.dst_rrftag1_o !== 6'd0) begin
            err_cnt++;
            $display("FAIL fill_single: alloc=%b en=%b%b tag1=%0d want 1 10 0",
                     bus.allocatable_o, bus.allocate_en1_o, bus.allocate_en2_o, bus.dst_rrftag1_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd0 || bus.rrfptr_o !== 6'd1 || bus.comptr_o !== 6'd1) begin
            err_cnt++;
            $display("FAIL fill_after: freenum=%0d rrfptr=%0d comptr=%0d want 0 1 1",
                     bus.freenum_o, bus.rrfptr_o, bus.comptr_o);
        end
    endtask

    task automatic test_wrap_and_overlap();
        do_reset();
        for (int i = 0; i < 31; i++) apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        apply(2'd1, 2'd0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) apply(2'd0, 2'd2, 1'b0, 1'b0, 6'd0);
        apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.dst_rrftag1_o !== 6'd63 || bus.dst_rrftag2_o !== 6'd0 || bus.allocate_en2_o !== 1'b1 ||
            bus.comptr_o !== 6'd10 || bus.freenum_o !== 7'd11) begin
            err_cnt++;
            $display("FAIL wrap_tags: tags=%0d,%0d en2=%b comptr=%0d freenum=%0d want 63,0 1 10 11",
                     bus.dst_rrftag1_o, bus.dst_rrftag2_o, bus.allocate_en2_o, bus.comptr_o, bus.freenum_o);
        end
        apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.rrfptr_o !== 6'd1 || bus.freenum_o !== 7'd9) begin
            err_cnt++;
            $display("FAIL wrap_ptr: rrfptr=%0d freenum=%0d want 1 9", bus.rrfptr_o, bus.freenum_o);
        end
        apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        apply(2'd2, 2'd2, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd5 || bus.allocate_en2_o !== 1'b1 || bus.rrfptr_o !== 6'd5) begin
            err_cnt++;
            $display("FAIL overlap_pre: freenum=%0d en2=%b rrfptr=%0d want 5 1 5",
                     bus.freenum_o, bus.allocate_en2_o, bus.rrfptr_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd5 || bus.comptr_o !== 6'd12 || bus.rrfptr_o !== 6'd7) begin
            err_cnt++;
            $display("FAIL overlap_post: freenum=%0d comptr=%0d rrfptr=%0d want 5 12 7",
                     bus.freenum_o, bus.comptr_o, bus.rrfptr_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 10; i++) apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 2; i++) apply(2'd0, 2'd2, 1'b0, 1'b0, 6'd0);
        apply(2'd2, 2'd1, 1'b0, 1'b1, 6'd12);
        vec_cnt++;
        if (bus.allocatable_o !== 1'b0 || bus.allocate_en1_o !== 1'b0 || bus.allocate_en2_o !== 1'b0 ||
            bus.rrfptr_o !== 6'd20 || bus.comptr_o !== 6'd4 || bus.freenum_o !== 7'd48) begin
            err_cnt++;
            $display("FAIL flush_cycle: alloc=%b en=%b%b rrfptr=%0d comptr=%0d freenum=%0d want 0 00 20 4 48",
                     bus.allocatable_o, bus.allocate_en1_o, bus.allocate_en2_o,
                     bus.rrfptr_o, bus.comptr_o, bus.freenum_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.rrfptr_o !== 6'd12 || bus.comptr_o !== 6'd5 || bus.freenum_o !== 7'd57 ||
            bus.dst_rrftag1_o !== 6'd12) begin
            err_cnt++;
            $display("FAIL flush_after: rrfptr=%0d comptr=%0d freenum=%0d tag1=%0d want 12 5 57 12",
                     bus.rrfptr_o, bus.comptr_o, bus.freenum_o, bus.dst_rrftag1_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b1, 6'd12);
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.rrfptr_o !== 6'd12 || bus.freenum_o !== 7'd57) begin
            err_cnt++;
            $display("FAIL flush_zero: rrfptr=%0d freenum=%0d want 12 57", bus.rrfptr_o, bus.freenum_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 17; i++) apply(2'd2, 2'd0, 1'b0, 1'b0, 6'd0);
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        vec_cnt++;
        if (bus.freenum_o !== 7'd30 || bus.rrfptr_o !== 6'd34) begin
            err_cnt++;
            $display("FAIL midfill: freenum=%0d rrfptr=%0d want 30 34", bus.freenum_o, bus.rrfptr_o);
        end
        #1;
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.freenum_o !== 7'd64 || bus.rrfptr_o !== 6'd0 || bus.comptr_o !== 6'd0 ||
            bus.dst_rrftag1_o !== 6'd0 || bus.dst_rrftag2_o !== 6'd1 || bus.allocate_en1_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: freenum=%0d rrfptr=%0d comptr=%0d tags=%0d,%0d en1=%b want 64 0 0 0,1 0",
                     bus.freenum_o, bus.rrfptr_o, bus.comptr_o, bus.dst_rrftag1_o,
                     bus.dst_rrftag2_o, bus.allocate_en1_o);
        end
        apply(2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_cnt            = 0;
        err_cnt            = 0;
        reset_n            = 1'b0;
        bus.req_num_i      = 2'd0;
        bus.com_num_i      = 2'd0;
        bus.stall_dp_i     = 1'b0;
        bus.flush_i        = 1'b0;
        bus.flush_rrfptr_i = 6'd0;
        test_reset();
        test_basic();
        test_fill();
        test_wrap_and_overlap();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
